// File: rtl/delay_line_sched_ctrl_if.sv
// delay_line_sched_ctrl_if: SRAM-side port bundle of the delay-line sequencer
// Signals:
//   sram_wen / sram_waddr  write strobe and circular write address
//   sram_ren / sram_raddr  read strobe and circular read address
//   valid_out              read data valid, sram_ren delayed by the SRAM read latency
// Modports: master = sequencer (drives), slave = SRAM / consumer (observes)
interface delay_line_sched_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_waddr;
    logic              sram_ren;
    logic [ADDR_W-1:0] sram_raddr;
    logic              valid_out;
    modport master (output sram_wen, sram_waddr, sram_ren, sram_raddr, valid_out);
    modport slave  (input  sram_wen, sram_waddr, sram_ren, sram_raddr, valid_out);
endinterface

// File: rtl/delay_line_sched_ctrl.sv
// delay_line_sched_ctrl: write/read sequencer for a memtile used as a long delay line
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous return to IDLE, latched configuration kept
//   start             pulse in IDLE: latch cfg_* and enter RUN
//   stall             only with DLY_CTRL_STALL_EN defined: freeze time and both loop nests
//   cfg_dims          active loop levels 1..3 (0 behaves as 1)
//   cfg_range/stride  per-level iteration count (0 behaves as 1) and schedule stride, level 0 innermost
//   cfg_sched_off     time of the first write
//   cfg_delay         read time = write time + cfg_delay
//   cfg_wr_start      base address of both circular pointers
//   sif               SRAM bundle: wen/waddr, ren/raddr, valid_out
//   busy, done        state != IDLE; one-cycle pulse when a run completes
//   overflow          sticky: a write found the buffer already holding DEPTH words
// Build option: DLY_CTRL_STALL_EN adds the stall input.
module delay_line_sched_ctrl #(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    start,
`ifdef DLY_CTRL_STALL_EN
    input  logic                    stall,
`endif
    input  logic [1:0]              cfg_dims,
    input  logic [CNT_W-1:0]        cfg_range [3],
    input  logic [CNT_W-1:0]        cfg_stride [3],
    input  logic [CNT_W-1:0]        cfg_sched_off,
    input  logic [CNT_W-1:0]        cfg_delay,
    input  logic [ADDR_W-1:0]       cfg_wr_start,
    delay_line_sched_ctrl_if.master sif,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);
    localparam int LW = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_W);
    typedef logic [2:0][CNT_W-1:0] vec_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_d;
    vec_t              range_q, stride_q, iw_q, ir_q, range_eff;
    logic [CNT_W-1:0]  off_q, delay_q, t_q, wcount_q, rcount_q;
    logic [ADDR_W-1:0] wr_start_q, waddr_q, raddr_q;
    logic [LW-1:0]     lat_q;
    logic [RD_LAT-1:0] vpipe_q;
    logic [1:0]        dims_eff;
    logic              rdone_q, wen_q, ren_q, adv, go, w_hit, r_hit;

    function automatic logic last_of(vec_t i, vec_t r);
        return i[0] == r[0] - 1'b1 && i[1] == r[1] - 1'b1 && i[2] == r[2] - 1'b1;
    endfunction

    // innermost-first odometer step; levels beyond cfg_dims have range 1 and stay at 0
    function automatic vec_t next_of(vec_t i, vec_t r);
        vec_t n;
        logic carry;
        carry = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n[k]  = !carry ? i[k] : i[k] == r[k] - 1'b1 ? '0 : i[k] + 1'b1;
            carry = carry && i[k] == r[k] - 1'b1;
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] time_of(vec_t i, vec_t s);
        return i[0] * s[0] + i[1] * s[1] + i[2] * s[2];
    endfunction

`ifdef DLY_CTRL_STALL_EN
    assign adv = !stall;
`else
    assign adv = 1'b1;
`endif

    // inactive levels and zero ranges collapse to a single iteration at latch time
    always_comb begin
        dims_eff = cfg_dims == 2'd0 ? 2'd1 : cfg_dims;
        for (int k = 0; k < 3; k++)
            range_eff[k] = k >= int'(dims_eff) || cfg_range[k] == '0 ? CNT_W'(1) : cfg_range[k];
    end

    assign go    = state_q == IDLE && start && !flush;
    assign w_hit = state_q == RUN && adv && !flush && t_q == off_q + time_of(iw_q, stride_q);
    assign r_hit = state_q != IDLE && !rdone_q && adv && !flush
                   && t_q == off_q + time_of(ir_q, stride_q) + delay_q;

    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = IDLE;
        else if (go)
            state_d = RUN;
        else if (state_q == RUN && w_hit && last_of(iw_q, range_q))
            state_d = DRAIN;
        else if (state_q == DRAIN && rdone_q && lat_q == '0)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            range_q    <= '0;
            stride_q   <= '0;
            off_q      <= '0;
            delay_q    <= '0;
            wr_start_q <= '0;
        end else if (go) begin
            range_q    <= range_eff;
            stride_q   <= {cfg_stride[2], cfg_stride[1], cfg_stride[0]};
            off_q      <= cfg_sched_off;
            delay_q    <= cfg_delay;
            wr_start_q <= cfg_wr_start;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q      <= '0;
            iw_q     <= '0;
            ir_q     <= '0;
            wcount_q <= '0;
            rcount_q <= '0;
            rdone_q  <= 1'b0;
            lat_q    <= '0;
            wen_q    <= 1'b0;
            ren_q    <= 1'b0;
            waddr_q  <= '0;
            raddr_q  <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wen_q <= w_hit;
            ren_q <= r_hit;
            done  <= state_q == DRAIN && state_d == IDLE && !flush;
            if (w_hit)
                waddr_q <= wr_start_q + wcount_q[ADDR_W-1:0];
            if (r_hit)
                raddr_q <= wr_start_q + rcount_q[ADDR_W-1:0];
            if (flush || go) begin
                t_q      <= '0;
                iw_q     <= '0;
                ir_q     <= '0;
                wcount_q <= '0;
                rcount_q <= '0;
                rdone_q  <= 1'b0;
                lat_q    <= '0;
                overflow <= overflow && !flush;
            end else begin
                if (state_q != IDLE && adv)
                    t_q <= t_q + 1'b1;
                if (w_hit) begin
                    iw_q     <= next_of(iw_q, range_q);
                    wcount_q <= wcount_q + 1'b1;
                end
                if (r_hit) begin
                    ir_q     <= next_of(ir_q, range_q);
                    rcount_q <= rcount_q + 1'b1;
                end
                // after the final read, stay in DRAIN until its data is valid
                if (r_hit && last_of(ir_q, range_q)) begin
                    rdone_q <= 1'b1;
                    lat_q   <= LW'(RD_LAT - 1);
                end else if (rdone_q && lat_q != '0)
                    lat_q <= lat_q - 1'b1;
                // occupancy is sampled before any same-cycle read retires
                if (w_hit && wcount_q - rcount_q >= DEPTH)
                    overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vpipe_q <= '0;
        else begin
            vpipe_q[0] <= ren_q;
            for (int i = 1; i < RD_LAT; i++)
                vpipe_q[i] <= vpipe_q[i-1];
        end
    end

    assign busy           = state_q != IDLE;
    assign sif.sram_wen   = wen_q;
    assign sif.sram_waddr = waddr_q;
    assign sif.sram_ren   = ren_q;
    assign sif.sram_raddr = raddr_q;
    assign sif.valid_out  = vpipe_q[RD_LAT-1];
endmodule

// File: tb/tb_delay_line_sched_ctrl.sv
// tb_delay_line_sched_ctrl: scoreboard bench for the delay-line sequencer
module tb_delay_line_sched_ctrl;
    localparam int AW = 9, CW = 16, DEPTH = 512;
    typedef struct {int t; int a;} ev_t;

    logic clk = 0, rst_n = 1, flush = 0, start = 0;
`ifdef DLY_CTRL_STALL_EN
    logic stall = 0;
`endif
    logic [1:0]    cfg_dims = 0;
    logic [CW-1:0] cfg_range [3];
    logic [CW-1:0] cfg_stride [3];
    logic [CW-1:0] cfg_sched_off = 0, cfg_delay = 0;
    logic [AW-1:0] cfg_wr_start = 0;
    logic          busy, done, overflow;

    delay_line_sched_ctrl_if #(.ADDR_W(AW)) sif ();

    delay_line_sched_ctrl #(.ADDR_W(AW), .CNT_W(CW), .RD_LAT(1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .start(start),
`ifdef DLY_CTRL_STALL_EN
        .stall(stall),
`endif
        .cfg_dims(cfg_dims),
        .cfg_range(cfg_range),
        .cfg_stride(cfg_stride),
        .cfg_sched_off(cfg_sched_off),
        .cfg_delay(cfg_delay),
        .cfg_wr_start(cfg_wr_start),
        .sif(sif),
        .busy(busy),
        .done(done),
        .overflow(overflow)
    );

    int  errors = 0, checks = 0;
    int  tb_t = 0, done_t = -1, done_cnt = 0, ov_t = -1;
    bit  launching = 0, ov_exp = 0;
    ev_t wq[$], rq[$];
    int  vq[$];

    always #5 clk = ~clk;

    // bench copy of the schedule time: 0 in the first RUN cycle
    always @(posedge clk) tb_t <= launching ? 0 : tb_t + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        bit ew, er, ev, ed;
        ev_t e;
        ew = wq.size() > 0 && wq[0].t == tb_t;
        er = rq.size() > 0 && rq[0].t == tb_t;
        ev = vq.size() > 0 && vq[0] == tb_t;
        ed = tb_t == done_t;
        if (ov_t >= 0 && tb_t == ov_t) ov_exp = 1;
        chk("wen", sif.sram_wen, ew);
        if (ew) begin
            e = wq.pop_front();
            chk("waddr", sif.sram_waddr, e.a);
        end
        chk("ren", sif.sram_ren, er);
        if (er) begin
            e = rq.pop_front();
            chk("raddr", sif.sram_raddr, e.a);
        end
        chk("valid_out", sif.valid_out, ev);
        if (ev) void'(vq.pop_front());
        chk("done", done, ed);
        if (done === 1'b1) done_cnt++;
        chk("overflow", overflow, ov_exp);
    end

    function automatic int sh(input int x, input int stall_at);
        return (stall_at >= 0 && x >= stall_at) ? x + 3 : x;
    endfunction

    task automatic plan(input int d, input int r [3], input int s [3], input int off, input int dly,
                        input int ws, input int stall_at);
        int de, re [3], rb;
        int tw[$];
        de = d == 0 ? 1 : d;
        for (int k = 0; k < 3; k++) re[k] = (k >= de || r[k] == 0) ? 1 : r[k];
        for (int i2 = 0; i2 < re[2]; i2++)
            for (int i1 = 0; i1 < re[1]; i1++)
                for (int i0 = 0; i0 < re[0]; i0++)
                    tw.push_back((off + i0 * s[0] + i1 * s[1] + i2 * s[2]) & 16'hFFFF);
        ov_t = -1;
        for (int n = 0; n < tw.size(); n++) begin
            wq.push_back('{sh(tw[n], stall_at) + 1, (ws + n) % DEPTH});
            rq.push_back('{sh(tw[n] + dly, stall_at) + 1, (ws + n) % DEPTH});
            vq.push_back(sh(tw[n] + dly, stall_at) + 2);
            if (ov_t < 0) begin
                rb = 0;
                for (int m = 0; m < tw.size(); m++) if (tw[m] + dly < tw[n]) rb++;
                if (n - rb >= DEPTH) ov_t = sh(tw[n], stall_at) + 1;
            end
        end
        done_t   = sh(tw[tw.size() - 1] + dly, stall_at) + 2;
        done_cnt = 0;
    endtask

    task automatic set_cfg(input int d, input int r [3], input int s [3], input int off, input int dly,
                           input int ws);
        cfg_dims = 2'(d);
        for (int k = 0; k < 3; k++) begin
            cfg_range[k]  = CW'(r[k]);
            cfg_stride[k] = CW'(s[k]);
        end
        cfg_sched_off = CW'(off);
        cfg_delay     = CW'(dly);
        cfg_wr_start  = AW'(ws);
    endtask

    task automatic launch();
        @(negedge clk);
        start = 1;
        launching = 1;
        @(posedge clk);
        #1 start = 0;
        launching = 0;
    endtask

    task automatic run(input int d, input int r [3], input int s [3], input int off, input int dly,
                       input int ws, input int stall_at, input bit poke);
        int n = 0;
        set_cfg(d, r, s, off, dly, ws);
        launch();
        plan(d, r, s, off, dly, ws, stall_at);
`ifdef DLY_CTRL_STALL_EN
        if (stall_at >= 0) begin
            repeat (stall_at) @(posedge clk);
            #1 stall = 1;
            repeat (3) @(posedge clk);
            #1 stall = 0;
        end
`endif
        if (poke) begin
            repeat (5) @(posedge clk);
            #1 start = 1;
            @(posedge clk);
            #1 start = 0;
        end
        while (done_cnt == 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("done_count", done_cnt, 1);
        chk("writes_left", wq.size(), 0);
        chk("reads_left", rq.size(), 0);
        chk("valids_left", vq.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            cfg_range[k]  = 0;
            cfg_stride[k] = 0;
        end
        #2 rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_wen", sif.sram_wen, 0);
        chk("rst_ren", sif.sram_ren, 0);
        chk("rst_valid", sif.valid_out, 0);
        chk("rst_waddr", sif.sram_waddr, 0);
        chk("rst_raddr", sif.sram_raddr, 0);
        rst_n = 1;
        @(posedge clk);

        run(1, '{8, 5, 9}, '{1, 7, 3}, 0, 4, 0, -1, 0);
        run(2, '{4, 3, 7}, '{1, 10, 0}, 0, 2, 0, -1, 1);
        run(3, '{2, 2, 2}, '{1, 3, 8}, 2, 5, 100, -1, 0);
        run(0, '{0, 4, 4}, '{5, 1, 1}, 3, 1, 7, -1, 0);
        run(1, '{4, 0, 0}, '{1, 0, 0}, 0, 2, 510, -1, 0);
        run(1, '{600, 0, 0}, '{1, 0, 0}, 0, 550, 0, -1, 0);

        set_cfg(1, '{8, 0, 0}, '{1, 0, 0}, 0, 4, 20);
        launch();
        plan(1, '{8, 0, 0}, '{1, 0, 0}, 0, 4, 20, -1);
        repeat (3) @(posedge clk);
        #1 flush = 1;
        @(posedge clk);
        #1 flush = 0;
        wq.delete();
        rq.delete();
        vq.delete();
        done_t = -1;
        ov_t   = -1;
        ov_exp = 0;
        @(negedge clk);
        chk("flush_busy", busy, 0);
        chk("flush_wen", sif.sram_wen, 0);
        chk("flush_ren", sif.sram_ren, 0);
        chk("flush_done", done, 0);
        chk("flush_overflow", overflow, 0);
        run(1, '{5, 0, 0}, '{2, 0, 0}, 1, 3, 20, -1, 0);

`ifdef DLY_CTRL_STALL_EN
        run(1, '{8, 0, 0}, '{1, 0, 0}, 0, 4, 0, 2, 0);
`endif

        set_cfg(1, '{8, 0, 0}, '{1, 0, 0}, 0, 4, 0);
        launch();
        plan(1, '{8, 0, 0}, '{1, 0, 0}, 0, 4, 0, -1);
        repeat (6) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("midrst_wen", sif.sram_wen, 0);
        chk("midrst_ren", sif.sram_ren, 0);
        chk("midrst_valid", sif.valid_out, 0);
        chk("midrst_busy", busy, 0);
        wq.delete();
        rq.delete();
        vq.delete();
        done_t = -1;
        ov_t   = -1;
        @(posedge clk);
        #1 rst_n = 1;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
